// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg -- definitions shared by the core front end.
//   fetch_state_e : fetch controller state encoding (BOOT/FETCH/WAIT/HALT)
//   CPU_RESET_PC  : default program counter after reset
//   PC_STEP       : byte distance between consecutive 16-bit instructions
//   OP_HLT/OP_B/OP_BR : opcode field values the decoder uses for halt and
//                   branches (fetch only sees their effect via hlt_dec and
//                   br_taken)
// ---------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [15:0] CPU_RESET_PC = 16'h0000;
  localparam logic [15:0] PC_STEP      = 16'h0002;

  localparam logic [3:0] OP_HLT = 4'hF;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;

endpackage

// File: rtl/CLA_16bit.sv
// ---------------------------------------------------------------------------
// CLA_16bit -- 16-bit two-level carry-lookahead adder/subtractor.
//   A, B : operands
//   Sub  : 1 selects A - B (B inverted, carry-in 1), 0 selects A + B
//   S    : result modulo 2^16 (carry-out is not produced)
// Four 4-bit groups; group carries come from a lookahead over the group
// generate/propagate terms, bit carries from a lookahead inside each group.
// ---------------------------------------------------------------------------
module CLA_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Sub,
  output logic [15:0] S
);

  logic [15:0] b_eff_s;
  logic [15:0] p_s;
  logic [14:0] g_s;   // bit 15 generate would only feed the absent carry-out
  logic [2:0]  gg_s;
  logic [2:0]  gp_s;
  logic [3:0]  gc_s;
  logic [15:0] c_s;

  assign b_eff_s = B ^ {16{Sub}};
  assign p_s     = A ^ b_eff_s;
  assign g_s     = A[14:0] & b_eff_s[14:0];

  // Group generate/propagate for the three lower groups.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      gg_s[k] = g_s[4*k+3]
              | (p_s[4*k+3] & g_s[4*k+2])
              | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
              | ((&p_s[4*k+3 -: 3]) & g_s[4*k]);
      gp_s[k] = &p_s[4*k+3 -: 4];
    end
  end

  // Second-level lookahead: carry into each 4-bit group.
  always_comb begin
    gc_s[0] = Sub;
    gc_s[1] = gg_s[0] | (gp_s[0] & Sub);
    gc_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]) | (gp_s[1] & gp_s[0] & Sub);
    gc_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0])
            | (gp_s[2] & gp_s[1] & gp_s[0] & Sub);
  end

  // First-level lookahead: carry into each bit from its group carry-in.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      c_s[4*k]   = gc_s[k];
      c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & gc_s[k]);
      c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+1] & p_s[4*k] & gc_s[k]);
      c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & gc_s[k]);
    end
  end

  assign S = p_s ^ c_s;

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl -- instruction fetch controller (BOOT/FETCH/WAIT/HALT).
// Parameter: RESET_PC   PC loaded on reset.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    hazard hold from the pipeline
//   br_taken, br_target      redirect from decode (wins over stall and halt)
//   hlt_dec                  halt opcode decoded this cycle
//   imem_req/addr/rdy/data   instruction-memory handshake (req/addr are
//                            combinational; addr is always the current pc)
//   if_valid/instr/pc_plus2  registered IF/ID payload
//   pc, flush, halted        current PC, IF/ID squash, core stopped
// Optional build macro FETCH_PERF_CNT_EN adds saturating counters
//   fetch_cnt (captured instructions) and stall_cnt (stall or WAIT cycles).
// ---------------------------------------------------------------------------
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = CPU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        hlt_dec,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc_plus2,
  output logic [15:0] pc,
  output logic        flush,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] stall_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic         if_valid_q, if_valid_d;
  logic [15:0]  if_instr_q, if_instr_d;
  logic [15:0]  if_pc2_q, if_pc2_d;
  logic         halted_q, halted_d;
  logic [15:0]  redir_q, redir_d;       // branch target seen while in WAIT
  logic         redir_vld_q, redir_vld_d;
  logic         hlt_pend_q, hlt_pend_d; // halt seen while in WAIT
  logic         capture_s;
  logic         mem_hs_s;
  logic [15:0]  pc_plus2_s;

  CLA_16bit u_pc_inc (
    .A   (pc_q),
    .B   (PC_STEP),
    .Sub (1'b0),
    .S   (pc_plus2_s)
  );

  assign imem_req  = ((state_q == ST_FETCH) || (state_q == ST_WAIT)) && !stall;
  assign imem_addr = pc_q;
  assign mem_hs_s  = imem_req && imem_rdy;
  assign flush     = br_taken && (state_q != ST_HALT);

  // Next-state and control: redirect > halt > stall > memory handshake.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_valid_d  = if_valid_q;
    halted_d    = halted_q;
    redir_d     = redir_q;
    redir_vld_d = redir_vld_q;
    hlt_pend_d  = hlt_pend_q;
    capture_s   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
        if (br_taken) begin
          pc_d       = br_target;
          if_valid_d = 1'b0;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_FETCH: begin
        if (br_taken) begin
          pc_d       = br_target;
          if_valid_d = 1'b0;
        end else if (hlt_dec) begin
          state_d    = ST_HALT;
          if_valid_d = 1'b0;
          halted_d   = 1'b1;
        end else if (stall) begin
          if_valid_d = if_valid_q;
        end else if (imem_rdy) begin
          capture_s  = 1'b1;
          pc_d       = pc_plus2_s;
          if_valid_d = 1'b1;
        end else begin
          state_d    = ST_WAIT;
          if_valid_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (mem_hs_s) begin
          // Outstanding transaction completes; decide what its data is worth.
          state_d     = ST_FETCH;
          redir_vld_d = 1'b0;
          hlt_pend_d  = 1'b0;
          if_valid_d  = 1'b0;
          if (br_taken) begin
            pc_d = br_target;
          end else if (redir_vld_q) begin
            pc_d = redir_q;
          end else if (hlt_pend_q || hlt_dec) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            capture_s  = 1'b1;
            pc_d       = pc_plus2_s;
            if_valid_d = 1'b1;
          end
        end else begin
          // pc must stay put until the memory answers; remember the events.
          if (br_taken) begin
            redir_d     = br_target;
            redir_vld_d = 1'b1;
            hlt_pend_d  = 1'b0;
          end else if (hlt_dec) begin
            hlt_pend_d = 1'b1;
          end else begin
            hlt_pend_d = hlt_pend_q;
          end
        end
      end
      ST_HALT: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // IF/ID payload: loads only on a captured instruction.
  always_comb begin
    if (capture_s) begin
      if_instr_d = imem_data;
      if_pc2_d   = pc_plus2_s;
    end else begin
      if_instr_d = if_instr_q;
      if_pc2_d   = if_pc2_q;
    end
  end

  // State and payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      if_valid_q  <= 1'b0;
      if_instr_q  <= 16'h0000;
      if_pc2_q    <= 16'h0000;
      halted_q    <= 1'b0;
      redir_q     <= 16'h0000;
      redir_vld_q <= 1'b0;
      hlt_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc2_q    <= if_pc2_d;
      halted_q    <= halted_d;
      redir_q     <= redir_d;
      redir_vld_q <= redir_vld_d;
      hlt_pend_q  <= hlt_pend_d;
    end
  end

  assign pc          = pc_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc_plus2 = if_pc2_q;
  assign halted      = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] stall_cnt_q;

  // Saturating performance counters; HALT cycles are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 16'h0000;
      stall_cnt_q <= 16'h0000;
    end else begin
      if (capture_s && (fetch_cnt_q != 16'hFFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 16'h0001;
      end else begin
        fetch_cnt_q <= fetch_cnt_q;
      end
      if ((stall || (state_q == ST_WAIT)) && (state_q != ST_HALT)
          && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'h0001;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl -- table-driven bench for fetch_ctrl. Each record holds one
// cycle of inputs, the expected combinational outputs during that cycle and
// the expected registered outputs after the following rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic        hlt_dec;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_plus2;
  logic [15:0] pc;
  logic        flush;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;
  logic [15:0] stall_cnt;
`endif

  fetch_ctrl #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .hlt_dec     (hlt_dec),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdy    (imem_rdy),
    .imem_data   (imem_data),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc_plus2 (if_pc_plus2),
    .pc          (pc),
    .flush       (flush),
    .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {rst, stall, br_taken, hlt_dec, imem_rdy}; rf = {imem_req, flush};
  // vh = {if_valid, halted}; cc enables the combinational checks.
  typedef struct {
    logic [4:0]  ctl;
    logic [15:0] tgt;
    logic [15:0] data;
    logic        cc;
    logic [1:0]  rf;
    logic [15:0] addr;
    logic [15:0] pc;
    logic [1:0]  vh;
    logic [15:0] instr;
    logic [15:0] pc2;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] pc;
    logic [1:0]  vh;
    logic [15:0] instr;
    logic [15:0] pc2;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [4:0] ctl, input logic [15:0] tgt,
                              input logic [15:0] data, input logic cc,
                              input logic [1:0] rf, input logic [15:0] addr,
                              input logic [15:0] epc, input logic [1:0] vh,
                              input logic [15:0] instr, input logic [15:0] pc2);
    vec_t v;
    v.ctl = ctl; v.tgt = tgt; v.data = data; v.cc = cc; v.rf = rf;
    v.addr = addr; v.pc = epc; v.vh = vh; v.instr = instr; v.pc2 = pc2;
    return v;
  endfunction

  function automatic void add(input logic [4:0] ctl, input logic [15:0] tgt,
                              input logic [15:0] data, input logic cc,
                              input logic [1:0] rf, input logic [15:0] addr,
                              input logic [15:0] epc, input logic [1:0] vh,
                              input logic [15:0] instr, input logic [15:0] pc2);
    tbl.push_back(mk(ctl, tgt, data, cc, rf, addr, epc, vh, instr, pc2));
  endfunction

  task automatic chk(input string nm, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    rst       = v.ctl[4];
    stall     = v.ctl[3];
    br_taken  = v.ctl[2];
    hlt_dec   = v.ctl[1];
    imem_rdy  = v.ctl[0];
    br_target = v.tgt;
    imem_data = v.data;
    #1;
    if (v.cc) begin
      chk("imem_req", idx, {15'h0000, imem_req}, {15'h0000, v.rf[1]});
      chk("flush", idx, {15'h0000, flush}, {15'h0000, v.rf[0]});
      chk("imem_addr", idx, imem_addr, v.addr);
    end
    e.idx = idx; e.pc = v.pc; e.vh = v.vh; e.instr = v.instr; e.pc2 = v.pc2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard vec %0d: got empty queue, expected one entry", idx);
    end else begin
      e = sb.pop_front();
      chk("pc", e.idx, pc, e.pc);
      chk("if_valid", e.idx, {15'h0000, if_valid}, {15'h0000, e.vh[1]});
      chk("halted", e.idx, {15'h0000, halted}, {15'h0000, e.vh[0]});
      chk("if_instr", e.idx, if_instr, e.instr);
      chk("if_pc_plus2", e.idx, if_pc_plus2, e.pc2);
    end
  endtask

  initial begin
    logic [15:0] exp_pc;
    logic [15:0] last_instr;
    logic [15:0] last_pc2;
    logic [15:0] dval;
    logic [3:0]  jb;
    int          dly;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fc0;
    logic [15:0] sc0;
    fc0 = 16'h0000;
    sc0 = 16'h0000;
`endif
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; hlt_dec = 1'b0;
    imem_rdy = 1'b0; br_target = 16'h0000; imem_data = 16'h0000;

    // 0-4: reset, BOOT, then back-to-back fetches 0000/0002/0004
    add(5'b10001, 16'h0000, 16'h0000, 1'b0, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000);
    add(5'b00001, 16'h0000, 16'h1111, 1'b1, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000);
    add(5'b00001, 16'h0000, 16'h1111, 1'b1, 2'b10, 16'h0000, 16'h0002, 2'b10, 16'h1111, 16'h0002);
    add(5'b00001, 16'h0000, 16'h2222, 1'b1, 2'b10, 16'h0002, 16'h0004, 2'b10, 16'h2222, 16'h0004);
    add(5'b00001, 16'h0000, 16'h3333, 1'b1, 2'b10, 16'h0004, 16'h0006, 2'b10, 16'h3333, 16'h0006);
    // 5: stall holds everything; 6: branch to 0010
    add(5'b01001, 16'h0000, 16'h4444, 1'b1, 2'b00, 16'h0006, 16'h0006, 2'b10, 16'h3333, 16'h0006);
    add(5'b00100, 16'h0010, 16'h0000, 1'b1, 2'b11, 16'h0006, 16'h0010, 2'b00, 16'h3333, 16'h0006);
    // 7-10: memory not ready for 3 cycles at 0010
    add(5'b00000, 16'h0000, 16'h0000, 1'b1, 2'b10, 16'h0010, 16'h0010, 2'b00, 16'h3333, 16'h0006);
    add(5'b00000, 16'h0000, 16'h0000, 1'b1, 2'b10, 16'h0010, 16'h0010, 2'b00, 16'h3333, 16'h0006);
    add(5'b00000, 16'h0000, 16'h0000, 1'b1, 2'b10, 16'h0010, 16'h0010, 2'b00, 16'h3333, 16'h0006);
    add(5'b00001, 16'h0000, 16'h5555, 1'b1, 2'b10, 16'h0010, 16'h0012, 2'b10, 16'h5555, 16'h0012);
    // 11-15: redirect to 0100 while waiting at 0020
    add(5'b00101, 16'h0020, 16'h6666, 1'b1, 2'b11, 16'h0012, 16'h0020, 2'b00, 16'h5555, 16'h0012);
    add(5'b00000, 16'h0000, 16'h0000, 1'b1, 2'b10, 16'h0020, 16'h0020, 2'b00, 16'h5555, 16'h0012);
    add(5'b00100, 16'h0100, 16'h0000, 1'b1, 2'b11, 16'h0020, 16'h0020, 2'b00, 16'h5555, 16'h0012);
    add(5'b00001, 16'h0000, 16'h7777, 1'b1, 2'b10, 16'h0020, 16'h0100, 2'b00, 16'h5555, 16'h0012);
    add(5'b00001, 16'h0000, 16'h8888, 1'b1, 2'b10, 16'h0100, 16'h0102, 2'b10, 16'h8888, 16'h0102);
    // 16-19: two redirects in one WAIT, the last one wins
    add(5'b00000, 16'h0000, 16'h0000, 1'b1, 2'b10, 16'h0102, 16'h0102, 2'b00, 16'h8888, 16'h0102);
    add(5'b00100, 16'h0200, 16'h0000, 1'b1, 2'b11, 16'h0102, 16'h0102, 2'b00, 16'h8888, 16'h0102);
    add(5'b00100, 16'h0300, 16'h0000, 1'b1, 2'b11, 16'h0102, 16'h0102, 2'b00, 16'h8888, 16'h0102);
    add(5'b00001, 16'h0000, 16'h9999, 1'b1, 2'b10, 16'h0102, 16'h0300, 2'b00, 16'h8888, 16'h0102);
    // 20-21: branch overrides stall
    add(5'b01101, 16'h0040, 16'hAAAA, 1'b1, 2'b01, 16'h0300, 16'h0040, 2'b00, 16'h8888, 16'h0102);
    add(5'b00001, 16'h0000, 16'hBBBB, 1'b1, 2'b10, 16'h0040, 16'h0042, 2'b10, 16'hBBBB, 16'h0042);
    // 22-23: pc wraps FFFE -> 0000
    add(5'b00101, 16'hFFFE, 16'hCCCC, 1'b1, 2'b11, 16'h0042, 16'hFFFE, 2'b00, 16'hBBBB, 16'h0042);
    add(5'b00001, 16'h0000, 16'hDDDD, 1'b1, 2'b10, 16'hFFFE, 16'h0000, 2'b10, 16'hDDDD, 16'h0000);
    // 24-27: halt in WAIT completes the access, drops its data, then halts
    add(5'b00000, 16'h0000, 16'h0000, 1'b1, 2'b10, 16'h0000, 16'h0000, 2'b00, 16'hDDDD, 16'h0000);
    add(5'b00010, 16'h0000, 16'h0000, 1'b1, 2'b10, 16'h0000, 16'h0000, 2'b00, 16'hDDDD, 16'h0000);
    add(5'b00001, 16'h0000, 16'hEEEE, 1'b1, 2'b10, 16'h0000, 16'h0000, 2'b01, 16'hDDDD, 16'h0000);
    add(5'b00101, 16'h1234, 16'h0000, 1'b1, 2'b00, 16'h0000, 16'h0000, 2'b01, 16'hDDDD, 16'h0000);
    // 28-30: reset, branch in BOOT to 0030, halt in FETCH
    add(5'b10000, 16'h0000, 16'h0000, 1'b1, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000);
    add(5'b00101, 16'h0030, 16'h0000, 1'b1, 2'b01, 16'h0000, 16'h0030, 2'b00, 16'h0000, 16'h0000);
    add(5'b00011, 16'h0000, 16'hF0F0, 1'b1, 2'b10, 16'h0030, 16'h0030, 2'b01, 16'h0000, 16'h0000);
    // 31-40: ten HALT cycles with assorted inputs, all ignored
    for (int j = 0; j < 10; j++) begin
      jb = 4'(j);
      add({1'b0, jb[0], 1'((j % 3) == 0), 1'((j % 4) == 1), ~jb[0]}, 16'h5555, 16'h9876,
          1'b1, 2'b00, 16'h0030, 16'h0030, 2'b01, 16'h0000, 16'h0000);
    end
    // 41: only reset leaves HALT
    add(5'b10000, 16'h0000, 16'h0000, 1'b1, 2'b00, 16'h0030, 16'h0000, 2'b00, 16'h0000, 16'h0000);
    // 42-46: reset mid-WAIT, late imem_rdy ignored
    add(5'b00000, 16'h0000, 16'h0000, 1'b1, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000);
    add(5'b00000, 16'h0000, 16'h0000, 1'b1, 2'b10, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000);
    add(5'b10000, 16'h0000, 16'h0000, 1'b1, 2'b10, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000);
    add(5'b00001, 16'h0000, 16'h1357, 1'b1, 2'b00, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000);
    add(5'b00001, 16'h0000, 16'h2468, 1'b1, 2'b10, 16'h0000, 16'h0002, 2'b10, 16'h2468, 16'h0002);
    // 47-48: branch and halt together, branch wins
    add(5'b00111, 16'h0080, 16'h0000, 1'b1, 2'b11, 16'h0002, 16'h0080, 2'b00, 16'h2468, 16'h0002);
    add(5'b00001, 16'h0000, 16'h4321, 1'b1, 2'b10, 16'h0080, 16'h0082, 2'b10, 16'h4321, 16'h0082);

    for (int i = 0; i < tbl.size(); i++) begin
`ifdef FETCH_PERF_CNT_EN
      if (i == 23) fc0 = fetch_cnt;
      if (i == 8) sc0 = stall_cnt;
`endif
      apply(tbl[i], i);
`ifdef FETCH_PERF_CNT_EN
      if (i == 23) chk("fetch_cnt_inc", i, fetch_cnt, fc0 + 16'h0001);
      if (i == 10) chk("stall_cnt_wait", i, stall_cnt, sc0 + 16'h0003);
`endif
    end

    // Random-latency fetches: address held during the wait, then captured.
    exp_pc     = 16'h0082;
    last_instr = 16'h4321;
    last_pc2   = 16'h0082;
    for (int k = 0; k < 4; k++) begin
      dly = int'($urandom_range(0, 3));
      for (int j = 0; j < dly; j++) begin
        apply(mk(5'b00000, 16'h0000, 16'h0000, 1'b1, 2'b10, exp_pc, exp_pc, 2'b00,
                 last_instr, last_pc2), 100 + k);
      end
      dval = 16'hC000 + 16'(k);
      apply(mk(5'b00001, 16'h0000, dval, 1'b1, 2'b10, exp_pc, exp_pc + 16'h0002, 2'b10,
               dval, exp_pc + 16'h0002), 100 + k);
      exp_pc     = exp_pc + 16'h0002;
      last_instr = dval;
      last_pc2   = exp_pc;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have ports stall (in, 1, hazard hold), br_taken (in, 1, redirect from decode) and br_target (in, 16, redirect address).
REQ-005 SHALL have port hlt_dec, input, 1, meaning a halt opcode was decoded this cycle.
REQ-006 SHALL have ports imem_req (out, 1), imem_addr (out, 16), imem_rdy (in, 1) and imem_data (in, 16), forming the instruction-memory handshake.
REQ-007 SHALL have ports if_valid (out, 1), if_instr (out, 16) and if_pc_plus2 (out, 16), forming the IF/ID payload.
REQ-008 SHALL have ports pc (out, 16, current PC), flush (out, 1, squash IF/ID) and halted (out, 1, core stopped).

Function
REQ-009 SHALL implement states BOOT, FETCH, WAIT and HALT.
REQ-010 SHALL go BOOT->FETCH unconditionally after one cycle.
REQ-011 SHALL drive imem_req = (FETCH or WAIT) && !stall, combinationally.
REQ-012 SHALL drive imem_addr = pc, combinationally.
REQ-013 SHALL hold imem_addr stable while a request is outstanding (in WAIT).
REQ-014 SHALL, in FETCH with imem_req && imem_rdy, register if_instr<=imem_data, if_pc_plus2<=pc+2 and if_valid<=1, and advance pc<=pc+2, giving 1-cycle latency.
REQ-015 SHALL, in FETCH with imem_req && !imem_rdy, enter WAIT.
REQ-016 SHALL, in WAIT with imem_rdy, capture as in REQ-014 and return to FETCH.
REQ-017 SHALL, while stall=1 and no redirect, hold pc, if_valid, if_instr and if_pc_plus2 unchanged.
REQ-018 SHALL drive flush = br_taken && state!=HALT, combinationally.
REQ-019 SHALL, on br_taken in BOOT or FETCH, load pc<=br_target and clear if_valid<=0 next cycle; br_taken overrides stall.
REQ-020 SHALL, on br_taken in WAIT, latch br_target into a redirect register and keep pc unchanged.
REQ-021 SHALL, when imem_rdy then arrives in WAIT with a redirect latched, discard the data (if_valid<=0), load pc<=redirect and return to FETCH.
REQ-022 SHALL, for a second br_taken during the same WAIT, let the last target win.
REQ-023 SHALL, on hlt_dec && !br_taken in FETCH, enter HALT next cycle with if_valid<=0, halted<=1 and pc frozen.
REQ-024 SHALL, on hlt_dec && !br_taken in WAIT, first complete the outstanding transaction, discard its data, and then enter HALT.
REQ-025 SHALL give br_taken priority over hlt_dec when both arrive in the same cycle.
REQ-026 SHALL leave HALT only through rst, ignoring all other inputs while in HALT.
REQ-027 SHALL wrap pc+2 modulo 2^16 (16'hFFFE -> 16'h0000) with no flag raised.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, load state=BOOT, pc=RESET_PC, if_valid=0, if_instr=0, if_pc_plus2=0, halted=0, redirect cleared and counters 0.
REQ-029 SHALL, on rst asserted mid-WAIT, drop imem_req the following cycle and discard any late imem_rdy.
REQ-030 SHALL give rst priority over every other input.

Configuration
REQ-031 SHALL, with FETCH_PERF_CNT_EN defined, add output ports fetch_cnt (16) and stall_cnt (16).
REQ-032 SHALL increment fetch_cnt once per captured instruction, saturating at 16'hFFFF.
REQ-033 SHALL increment stall_cnt once per cycle in which stall=1 or state==WAIT, saturating at 16'hFFFF.
REQ-034 SHALL, with FETCH_PERF_CNT_EN undefined, omit both counter ports and their logic, leaving all other behaviour identical.

Structure
REQ-035 SHALL place the state encoding, the default RESET_PC constant and the HLT/B/BR opcode constants in shared package cpu_pkg.
REQ-036 SHALL compute pc+2 with one instance of the existing CLA_16bit sub-module (Sub=0, B=16'h0002).
REQ-037 SHALL contain no other sub-module.

Verification
REQ-038 SHALL cover: reset, then imem_rdy held 1 -> BOOT for one cycle, then imem_addr 0000,0002,0004 on consecutive cycles, with if_valid=1 from cycle 3.
REQ-039 SHALL cover: imem_rdy low for 3 cycles at pc=0x0010 -> imem_addr held at 0x0010, then if_instr=data and pc=0x0012.
REQ-040 SHALL cover: br_taken, br_target=0x0100 during WAIT at pc=0x0020 -> returned data discarded, next fetch address 0x0100, flush=1 for exactly that cycle.
REQ-041 SHALL cover: stall=1 and br_taken same cycle, target 0x0040 -> pc=0x0040 and if_valid=0 next cycle.
REQ-042 SHALL cover: hlt_dec at pc=0x0030 -> halted=1 next cycle, imem_req=0, pc stays 0x0030 for 10 cycles, until rst restores pc=RESET_PC.
REQ-043 SHALL cover: pc=0xFFFE with a fetch -> pc=0x0000 and if_pc_plus2=0x0000; with FETCH_PERF_CNT_EN defined, fetch_cnt increments by 1.
